// File: rtl/scoreboard_fu_table_pkg.sv
// Shared types and default widths for the scoreboard FU-status table.
// The per-FU lifecycle enum is used by both the table and its exec timers.
package scoreboard_fu_table_pkg;

   localparam int DEF_NUM_FUS  = 4;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_REG_BITS = 5;
   localparam int DEF_FU_BITS  = 2;
   localparam int DEF_OP_BITS  = 3;
   localparam int DEF_LAT_BITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_OPS = 2'd1,
      ST_EXEC     = 2'd2,
      ST_DONE     = 2'd3
   } fu_state_e;

endpackage

// File: rtl/scoreboard_fu_table_if.sv
// Issue / grant / status bundle between the issue stage, arbiters and the FU table.
// The master side is the pipeline control; the slave side is the table itself.
interface scoreboard_fu_table_if
   import scoreboard_fu_table_pkg::*;
#(
   parameter int NUM_FUS  = DEF_NUM_FUS,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int REG_BITS = DEF_REG_BITS,
   parameter int FU_BITS  = DEF_FU_BITS,
   parameter int OP_BITS  = DEF_OP_BITS,
   parameter int LAT_BITS = DEF_LAT_BITS
);

   logic                         issue_valid;
   logic                         issue_ready;
   logic [FU_BITS-1:0]           issue_fu;
   logic [OP_BITS-1:0]           issue_op;
   logic [REG_BITS-1:0]          issue_fi;
   logic [REG_BITS-1:0]          issue_fj;
   logic [REG_BITS-1:0]          issue_fk;
   logic [LAT_BITS-1:0]          issue_lat;
   logic [NUM_FUS-1:0]           read_grant;
   logic [NUM_FUS-1:0]           write_grant;
   logic [NUM_FUS-1:0]           busy;
   logic [NUM_FUS-1:0]           rj;
   logic [NUM_FUS-1:0]           rk;
   logic [NUM_FUS-1:0]           read_req;
   logic [NUM_FUS-1:0]           exec_done;
   logic [NUM_FUS-1:0]           write_ok;
   logic [NUM_FUS*OP_BITS-1:0]   fu_op;
   logic [NUM_FUS*REG_BITS-1:0]  fu_dest;
   logic [NUM_REGS*NUM_FUS-1:0]  reg_result_fu;
   logic                         protocol_err;

   modport master (
      output issue_valid, issue_fu, issue_op, issue_fi, issue_fj, issue_fk, issue_lat,
      output read_grant, write_grant,
      input  issue_ready, busy, rj, rk, read_req, exec_done, write_ok,
      input  fu_op, fu_dest, reg_result_fu, protocol_err
   );

   modport slave (
      input  issue_valid, issue_fu, issue_op, issue_fi, issue_fj, issue_fk, issue_lat,
      input  read_grant, write_grant,
      output issue_ready, busy, rj, rk, read_req, exec_done, write_ok,
      output fu_op, fu_dest, reg_result_fu, protocol_err
   );

endinterface

// File: rtl/scoreboard_fu_table_exec_timer.sv
// Per-FU lifecycle FSM with an execution-latency down-counter.
// Latency is captured at issue and started when the operands are read.
module scoreboard_fu_table_exec_timer
   import scoreboard_fu_table_pkg::*;
#(
   parameter int LAT_BITS = DEF_LAT_BITS
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                issue_en,
   input  logic [LAT_BITS-1:0] issue_lat,
   input  logic                read_en,
   input  logic                write_en,
   output fu_state_e           state,
   output logic                exec_done
);

   fu_state_e           state_next;
   logic [LAT_BITS-1:0] lat_q;
   logic [LAT_BITS-1:0] lat_next;
   logic [LAT_BITS-1:0] cnt;
   logic [LAT_BITS-1:0] cnt_next;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= ST_IDLE;
         lat_q <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         lat_q <= lat_next;
         cnt   <= cnt_next;
      end
   end

   // Counter is loaded with lat-1 so DONE appears lat+1 cycles after the read;
   // a zero latency skips EXEC entirely.
   always_comb begin
      state_next = state;
      lat_next   = lat_q;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (issue_en) begin
               state_next = ST_WAIT_OPS;
               lat_next   = issue_lat;
            end
         end
         ST_WAIT_OPS: begin
            if (read_en) begin
               if (lat_q == '0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_EXEC;
                  cnt_next   = lat_q - LAT_BITS'(1);
               end
            end
         end
         ST_EXEC: begin
            if (cnt == '0) state_next = ST_DONE;
            else           cnt_next   = cnt - LAT_BITS'(1);
         end
         ST_DONE: begin
            if (write_en) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign exec_done = (state == ST_DONE);

endmodule

// File: rtl/scoreboard_fu_table.sv
// Scoreboard FU-status table: per-FU operand tracking, register result status,
// WAW-gated issue, WAR-gated writeback, writeback-to-issue bypass and a sticky error flag.
module scoreboard_fu_table
   import scoreboard_fu_table_pkg::*;
#(
   parameter int NUM_FUS  = DEF_NUM_FUS,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int REG_BITS = DEF_REG_BITS,
   parameter int FU_BITS  = DEF_FU_BITS,
   parameter int OP_BITS  = DEF_OP_BITS,
   parameter int LAT_BITS = DEF_LAT_BITS,
   parameter bit R0_ZERO  = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  flush,
   scoreboard_fu_table_if.slave sb
);

   logic                               clr;
   fu_state_e                          state [NUM_FUS];
   logic [NUM_FUS-1:0]                 busy, exec_done, read_req, write_ok, war;
   logic [NUM_FUS-1:0]                 rd_fire, wr_fire, rj, rk;
   logic [NUM_FUS-1:0][OP_BITS-1:0]    op;
   logic [NUM_FUS-1:0][REG_BITS-1:0]   fi, fj, fk;
   logic [NUM_FUS-1:0][NUM_FUS-1:0]    qj, qk;
   logic [NUM_REGS-1:0][NUM_FUS-1:0]   result_fu;
   logic [NUM_FUS-1:0]                 issue_sel, byp_j, byp_k, qj_new, qk_new;
   logic                               fu_free, issue_ready, issue_fire, err_event;

   assign clr = rst | flush;

   for (genvar g = 0; g < NUM_FUS; g++) begin : g_fu
      scoreboard_fu_table_exec_timer #(.LAT_BITS(LAT_BITS)) u_timer (
         .clk       (clk),
         .clr       (clr),
         .issue_en  (issue_fire && issue_sel[g]),
         .issue_lat (sb.issue_lat),
         .read_en   (rd_fire[g]),
         .write_en  (wr_fire[g]),
         .state     (state[g]),
         .exec_done (exec_done[g])
      );
      assign busy[g]     = (state[g] != ST_IDLE);
      assign read_req[g] = (state[g] == ST_WAIT_OPS) && rj[g] && rk[g];
      assign rd_fire[g]  = sb.read_grant[g] && read_req[g];
      assign write_ok[g] = exec_done[g] && !war[g];
      assign wr_fire[g]  = sb.write_grant[g] && write_ok[g];
   end

   // A result may not be written while another FU still has to read the old value.
   always_comb begin
      war = '0;
      for (int f = 0; f < NUM_FUS; f++) begin
         for (int g = 0; g < NUM_FUS; g++) begin
            if (g != f && ((fj[g] == fi[f] && rj[g]) || (fk[g] == fi[f] && rk[g])))
               war[f] = 1'b1;
         end
      end
   end

   // Issue acceptance plus source status, with same-cycle writebacks bypassed in.
   always_comb begin
      fu_free   = 1'b0;
      issue_sel = '0;
      byp_j     = '0;
      byp_k     = '0;
      for (int f = 0; f < NUM_FUS; f++) begin
         if (sb.issue_fu == FU_BITS'(f)) begin
            issue_sel[f] = 1'b1;
            fu_free      = !busy[f];
         end
         if (wr_fire[f] && fi[f] == sb.issue_fj) byp_j[f] = 1'b1;
         if (wr_fire[f] && fi[f] == sb.issue_fk) byp_k[f] = 1'b1;
      end
      qj_new = result_fu[sb.issue_fj] & ~byp_j;
      qk_new = result_fu[sb.issue_fk] & ~byp_k;
      if (R0_ZERO && sb.issue_fj == '0) qj_new = '0;
      if (R0_ZERO && sb.issue_fk == '0) qk_new = '0;
      issue_ready = fu_free && (result_fu[sb.issue_fi] == '0);
      issue_fire  = sb.issue_valid && issue_ready;
      err_event   = (sb.issue_valid && !issue_ready)
                  || |(sb.read_grant & ~read_req)
                  || |(sb.write_grant & ~write_ok);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         op <= '0;
         fi <= '0;
         fj <= '0;
         fk <= '0;
         qj <= '0;
         qk <= '0;
         rj <= '0;
         rk <= '0;
      end else begin
         for (int f = 0; f < NUM_FUS; f++) begin
            if (issue_fire && issue_sel[f]) begin
               op[f] <= sb.issue_op;
               fi[f] <= sb.issue_fi;
               fj[f] <= sb.issue_fj;
               fk[f] <= sb.issue_fk;
               qj[f] <= qj_new;
               qk[f] <= qk_new;
               rj[f] <= (qj_new == '0);
               rk[f] <= (qk_new == '0);
            end else begin
               if (rd_fire[f]) begin
                  rj[f] <= 1'b0;
                  rk[f] <= 1'b0;
               end
               if (|(qj[f] & wr_fire)) begin
                  qj[f] <= qj[f] & ~wr_fire;
                  rj[f] <= 1'b1;
               end
               if (|(qk[f] & wr_fire)) begin
                  qk[f] <= qk[f] & ~wr_fire;
                  rk[f] <= 1'b1;
               end
            end
         end
      end
   end

   // Issue is ordered after the writeback clears so a new producer always wins.
   always_ff @(posedge clk) begin
      if (clr) begin
         result_fu <= '0;
      end else begin
         for (int f = 0; f < NUM_FUS; f++) begin
            if (wr_fire[f]) result_fu[fi[f]] <= '0;
         end
         if (issue_fire && !(R0_ZERO && sb.issue_fi == '0))
            result_fu[sb.issue_fi] <= issue_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (clr)            sb.protocol_err <= 1'b0;
      else if (err_event) sb.protocol_err <= 1'b1;
   end

   assign sb.issue_ready   = issue_ready;
   assign sb.busy          = busy;
   assign sb.rj            = rj;
   assign sb.rk            = rk;
   assign sb.read_req      = read_req;
   assign sb.exec_done     = exec_done;
   assign sb.write_ok      = write_ok;
   assign sb.fu_op         = op;
   assign sb.fu_dest       = fi;
   assign sb.reg_result_fu = result_fu;

endmodule

// File: tb/tb_scoreboard_fu_table.sv
// Directed bench for the scoreboard FU table: reset, RAW, WAW, WAR, latency/bypass, illegal/flush.
module tb_scoreboard_fu_table;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   checks = 0;
   int   passed = 0;
   logic [127:0] exp_rf;

   scoreboard_fu_table_if sb_if ();

   scoreboard_fu_table dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .sb    (sb_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      sb_if.issue_valid = 1'b0;
      sb_if.issue_fu    = '0;
      sb_if.issue_op    = '0;
      sb_if.issue_fi    = '0;
      sb_if.issue_fj    = '0;
      sb_if.issue_fk    = '0;
      sb_if.issue_lat   = '0;
      sb_if.read_grant  = '0;
      sb_if.write_grant = '0;
   endtask

   task automatic do_issue(input logic [1:0] fu, input logic [2:0] op, input logic [4:0] fi,
                           input logic [4:0] fj, input logic [4:0] fk, input logic [3:0] lat);
      sb_if.issue_valid = 1'b1;
      sb_if.issue_fu    = fu;
      sb_if.issue_op    = op;
      sb_if.issue_fi    = fi;
      sb_if.issue_fj    = fj;
      sb_if.issue_fk    = fk;
      sb_if.issue_lat   = lat;
      step();
      clear_inputs();
      #1;
   endtask

   task automatic do_read(input logic [3:0] mask);
      sb_if.read_grant = mask;
      step();
      sb_if.read_grant = '0;
      #1;
   endtask

   task automatic do_write(input logic [3:0] mask);
      sb_if.write_grant = mask;
      step();
      sb_if.write_grant = '0;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++; if (sb_if.busy !== 4'b0000) $display("[TB] FAIL reset_busy got %b want 0000", sb_if.busy); else passed++;
      checks++; if (sb_if.rj !== 4'b0000) $display("[TB] FAIL reset_rj got %b want 0000", sb_if.rj); else passed++;
      checks++; if (sb_if.rk !== 4'b0000) $display("[TB] FAIL reset_rk got %b want 0000", sb_if.rk); else passed++;
      checks++; if (sb_if.reg_result_fu !== 128'd0) $display("[TB] FAIL reset_result_fu got %h want 0", sb_if.reg_result_fu); else passed++;
      checks++; if (sb_if.protocol_err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", sb_if.protocol_err); else passed++;
      checks++; if (sb_if.issue_ready !== 1'b1) $display("[TB] FAIL reset_issue_ready got %b want 1", sb_if.issue_ready); else passed++;
   endtask

   task automatic test_raw();
      do_issue(2'd0, 3'd1, 5'd3, 5'd1, 5'd2, 4'd2);
      do_issue(2'd1, 3'd2, 5'd5, 5'd3, 5'd4, 4'd0);
      checks++; if (sb_if.rj !== 4'b0001) $display("[TB] FAIL raw_rj got %b want 0001", sb_if.rj); else passed++;
      checks++; if (sb_if.rk !== 4'b0011) $display("[TB] FAIL raw_rk got %b want 0011", sb_if.rk); else passed++;
      checks++; if (sb_if.reg_result_fu[12 +: 4] !== 4'b0001) $display("[TB] FAIL raw_r3_owner got %b want 0001", sb_if.reg_result_fu[12 +: 4]); else passed++;
      checks++; if (sb_if.reg_result_fu[20 +: 4] !== 4'b0010) $display("[TB] FAIL raw_r5_owner got %b want 0010", sb_if.reg_result_fu[20 +: 4]); else passed++;
      checks++; if (sb_if.fu_dest[4:0] !== 5'd3) $display("[TB] FAIL raw_fu0_dest got %0d want 3", sb_if.fu_dest[4:0]); else passed++;
      do_read(4'b0001);
      step();
      step();
      checks++; if (sb_if.write_ok !== 4'b0001) $display("[TB] FAIL raw_write_ok got %b want 0001", sb_if.write_ok); else passed++;
      do_write(4'b0001);
      checks++; if (sb_if.rj !== 4'b0010) $display("[TB] FAIL raw_rj_after_wb got %b want 0010", sb_if.rj); else passed++;
      checks++; if (sb_if.read_req !== 4'b0010) $display("[TB] FAIL raw_read_req got %b want 0010", sb_if.read_req); else passed++;
      checks++; if (sb_if.reg_result_fu[12 +: 4] !== 4'b0000) $display("[TB] FAIL raw_r3_cleared got %b want 0000", sb_if.reg_result_fu[12 +: 4]); else passed++;
      do_read(4'b0010);
      checks++; if (sb_if.exec_done !== 4'b0010) $display("[TB] FAIL raw_lat0_done got %b want 0010", sb_if.exec_done); else passed++;
      do_write(4'b0010);
      checks++; if (sb_if.busy !== 4'b0000) $display("[TB] FAIL raw_end_busy got %b want 0000", sb_if.busy); else passed++;
   endtask

   task automatic test_waw();
      do_issue(2'd0, 3'd1, 5'd3, 5'd1, 5'd2, 4'd0);
      sb_if.issue_fu = 2'd2;
      sb_if.issue_fi = 5'd3;
      #1;
      checks++; if (sb_if.issue_ready !== 1'b0) $display("[TB] FAIL waw_blocked got %b want 0", sb_if.issue_ready); else passed++;
      do_read(4'b0001);
      do_write(4'b0001);
      checks++; if (sb_if.issue_ready !== 1'b1) $display("[TB] FAIL waw_released got %b want 1", sb_if.issue_ready); else passed++;
      do_issue(2'd2, 3'd1, 5'd3, 5'd1, 5'd2, 4'd0);
      checks++; if (sb_if.busy !== 4'b0100) $display("[TB] FAIL waw_issue_busy got %b want 0100", sb_if.busy); else passed++;
      checks++; if (sb_if.reg_result_fu[12 +: 4] !== 4'b0100) $display("[TB] FAIL waw_r3_owner got %b want 0100", sb_if.reg_result_fu[12 +: 4]); else passed++;
      do_read(4'b0100);
      do_write(4'b0100);
   endtask

   task automatic test_war();
      do_issue(2'd0, 3'd1, 5'd9, 5'd1, 5'd2, 4'd0);
      do_issue(2'd1, 3'd2, 5'd8, 5'd7, 5'd9, 4'd1);
      do_issue(2'd2, 3'd3, 5'd7, 5'd1, 5'd2, 4'd0);
      do_read(4'b0100);
      checks++; if (sb_if.exec_done !== 4'b0100) $display("[TB] FAIL war_fu2_done got %b want 0100", sb_if.exec_done); else passed++;
      checks++; if (sb_if.write_ok !== 4'b0000) $display("[TB] FAIL war_blocked got %b want 0000", sb_if.write_ok); else passed++;
      do_read(4'b0001);
      do_write(4'b0001);
      checks++; if (sb_if.read_req !== 4'b0010) $display("[TB] FAIL war_fu1_ready got %b want 0010", sb_if.read_req); else passed++;
      checks++; if (sb_if.write_ok !== 4'b0000) $display("[TB] FAIL war_still_blocked got %b want 0000", sb_if.write_ok); else passed++;
      do_read(4'b0010);
      checks++; if (sb_if.write_ok !== 4'b0100) $display("[TB] FAIL war_released got %b want 0100", sb_if.write_ok); else passed++;
      do_write(4'b0100);
      do_write(4'b0010);
      checks++; if (sb_if.busy !== 4'b0000) $display("[TB] FAIL war_end_busy got %b want 0000", sb_if.busy); else passed++;
      checks++; if (sb_if.protocol_err !== 1'b0) $display("[TB] FAIL war_no_err got %b want 0", sb_if.protocol_err); else passed++;
   endtask

   task automatic test_latency_bypass();
      do_issue(2'd0, 3'd1, 5'd3, 5'd1, 5'd2, 4'd3);
      do_read(4'b0001);
      step();
      step();
      checks++; if (sb_if.exec_done !== 4'b0000) $display("[TB] FAIL lat3_early got %b want 0000", sb_if.exec_done); else passed++;
      step();
      checks++; if (sb_if.exec_done !== 4'b0001) $display("[TB] FAIL lat3_done got %b want 0001", sb_if.exec_done); else passed++;
      sb_if.write_grant = 4'b0001;
      sb_if.issue_valid = 1'b1;
      sb_if.issue_fu    = 2'd1;
      sb_if.issue_op    = 3'd4;
      sb_if.issue_fi    = 5'd6;
      sb_if.issue_fj    = 5'd3;
      sb_if.issue_fk    = 5'd4;
      sb_if.issue_lat   = 4'd0;
      step();
      clear_inputs();
      #1;
      checks++; if (sb_if.rj !== 4'b0010) $display("[TB] FAIL bypass_rj got %b want 0010", sb_if.rj); else passed++;
      checks++; if (sb_if.busy !== 4'b0010) $display("[TB] FAIL bypass_busy got %b want 0010", sb_if.busy); else passed++;
      checks++; if (sb_if.reg_result_fu[12 +: 4] !== 4'b0000) $display("[TB] FAIL bypass_r3_cleared got %b want 0000", sb_if.reg_result_fu[12 +: 4]); else passed++;
      checks++; if (sb_if.fu_op[5:3] !== 3'd4) $display("[TB] FAIL bypass_fu1_op got %0d want 4", sb_if.fu_op[5:3]); else passed++;
      do_issue(2'd2, 3'd5, 5'd0, 5'd1, 5'd2, 4'd0);
      exp_rf = '0;
      exp_rf[24 +: 4] = 4'b0010;
      checks++; if (sb_if.reg_result_fu !== exp_rf) $display("[TB] FAIL r0_untracked got %h want %h", sb_if.reg_result_fu, exp_rf); else passed++;
      do_read(4'b0110);
      do_write(4'b0110);
      checks++; if (sb_if.busy !== 4'b0000) $display("[TB] FAIL multi_wb_busy got %b want 0000", sb_if.busy); else passed++;
   endtask

   task automatic test_illegal_flush();
      do_write(4'b1000);
      checks++; if (sb_if.protocol_err !== 1'b1) $display("[TB] FAIL illegal_err got %b want 1", sb_if.protocol_err); else passed++;
      checks++; if (sb_if.busy !== 4'b0000) $display("[TB] FAIL illegal_no_change got %b want 0000", sb_if.busy); else passed++;
      do_issue(2'd0, 3'd1, 5'd3, 5'd1, 5'd2, 4'd5);
      do_read(4'b0001);
      step();
      flush = 1'b1;
      sb_if.issue_valid = 1'b1;
      sb_if.issue_fu    = 2'd1;
      sb_if.issue_fi    = 5'd4;
      step();
      flush = 1'b0;
      clear_inputs();
      #1;
      checks++; if (sb_if.busy !== 4'b0000) $display("[TB] FAIL flush_busy got %b want 0000", sb_if.busy); else passed++;
      checks++; if (sb_if.reg_result_fu !== 128'd0) $display("[TB] FAIL flush_result_fu got %h want 0", sb_if.reg_result_fu); else passed++;
      checks++; if (sb_if.protocol_err !== 1'b0) $display("[TB] FAIL flush_err got %b want 0", sb_if.protocol_err); else passed++;
      checks++; if (sb_if.fu_dest !== 20'd0) $display("[TB] FAIL flush_dest got %h want 0", sb_if.fu_dest); else passed++;
      repeat (8) step();
      checks++; if (sb_if.exec_done !== 4'b0000) $display("[TB] FAIL flush_no_done got %b want 0000", sb_if.exec_done); else passed++;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_raw();
      test_waw();
      test_war();
      test_latency_bypass();
      test_illegal_flush();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
